// File: rtl/sub_nibble_serial_pkg.sv
// Shared constants, state encoding and helpers for the nibble-serial subtractor.
package sub_nibble_serial_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Number of 4-bit slices needed to cover an operand of the given width.
  function automatic int unsigned nibbles(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/sub_nibble_serial_cla.sv
// Combinational 4-bit carry-lookahead slice with fully expanded carries.
module cla_slice_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       c3,
  output logic       c4
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;

  // Generate/propagate terms and two-level carry expressions.
  always_comb begin
    g  = a & b;
    p  = a | b;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cin);
    sum = a ^ b ^ {c3, c2, c1, cin};
  end

endmodule

// File: rtl/sub_nibble_serial.sv
// Multi-cycle subtractor: diff = a - b - bin, one nibble per clock via a 4-bit CLA slice.
module sub_nibble_serial
  import sub_nibble_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int unsigned N     = nibbles(WIDTH);
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("sub_nibble_serial: WIDTH must be a non-zero multiple of 4");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [CNT_W+1:0]   base;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_c3;
  logic               slice_c4;

  // Select the current nibble of the latched minuend and inverted subtrahend.
  always_comb begin
    base    = {cnt_q, 2'b00};
    slice_a = a_q[base +: SLICE_W];
    slice_b = nb_q[base +: SLICE_W];
  end

  cla_slice_4 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .sum (slice_sum),
    .c3  (slice_c3),
    .c4  (slice_c4)
  );

  // Next-state, datapath update and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    nb_d    = nb_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          nb_d    = ~b;
          carry_d = ~bin;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        diff_d[base +: SLICE_W] = slice_sum;
        carry_d = slice_c4;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bout_d  = ~slice_c4;
          ovf_d   = slice_c3 ^ slice_c4;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      nb_q    <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      nb_q    <= nb_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = diff_q;
    bout      = bout_q;
    overflow  = ovf_q;
  end

endmodule

// File: tb/tb_sub_nibble_serial.sv
// Self-checking bench for sub_nibble_serial at WIDTH=16.
module tb_sub_nibble_serial;

  localparam int unsigned W = 16;
  localparam int unsigned N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  sub_nibble_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                output logic [W-1:0] md, output logic mbo, output logic mov);
    int ua;
    int ub;
    int sa;
    int sb;
    int sd;
    ua  = int'(ma);
    ub  = int'(mb);
    sa  = int'($signed(ma));
    sb  = int'($signed(mb));
    sd  = sa - sb - int'(mbin);
    md  = W'(ua - ub - int'(mbin));
    mbo = (ua < ub + int'(mbin));
    mov = (sd > 32767) || (sd < -32768);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand pair and return just after the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a = ta; b = tb; bin = tbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'($urandom);
  endtask

  // Called just after the accepting edge: measure latency, check result, hand off.
  task automatic finish_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tbin);
    logic [W-1:0] ed;
    logic         ebo;
    logic         eov;
    int           lat = 0;
    model(ta, tb, tbin, ed, ebo, eov);
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(N));
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(ebo));
    check({tag, "_ovf"}, 32'(overflow), 32'(eov));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_handoff_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_handoff_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbin);
    start_op(ta, tb, tbin);
    finish_op(tag, ta, tb, tbin);
  endtask

  initial begin
    logic [W-1:0] hold_d;
    logic         hold_bo;
    logic         hold_ov;
    int           lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick();

    run_op("basic", 16'h1234, 16'h0034, 1'b0);
    run_op("underflow", 16'h0000, 16'h0001, 1'b0);
    run_op("sovf_neg", 16'h8000, 16'h0001, 1'b0);
    run_op("sovf_pos", 16'h7FFF, 16'hFFFF, 1'b0);
    run_op("bin_ripple", 16'h0010, 16'h000F, 1'b1);
    run_op("bin_zero", 16'h0000, 16'h0000, 1'b1);

    // Backpressure: hold out_ready low, offer a second operation meanwhile.
    start_op(16'hABCD, 16'h1357, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("bp_latency", 32'(lat), 32'(N));
    model(16'hABCD, 16'h1357, 1'b1, hold_d, hold_bo, hold_ov);
    a = 16'h4000; b = 16'h8000; bin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_diff", 32'(diff), 32'(hold_d));
      check("bp_bout", 32'(bout), 32'(hold_bo));
      check("bp_ovf", 32'(overflow), 32'(hold_ov));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_eh_valid", 32'(out_valid), 32'd0);
    check("bp_eh_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp_accept_eh1", 32'(in_ready), 32'd0);
    finish_op("bp_second", 16'h4000, 16'h8000, 1'b0);

    // Reset during the second CALC cycle aborts the operation.
    start_op(16'h1234, 16'h1111, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("abort_no_result", 32'(out_valid), 32'd0);
    end
    run_op("after_abort", 16'h0005, 16'h0003, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rbin;
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      if (i % 8 == 1) ra = {1'b1, W'($urandom) >> 1};
      run_op("random", ra, rb, rbin);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sub_nibble_serial.md
# sub_nibble_serial

Multi-cycle two's-complement subtractor that computes `diff = a - b - bin` for a `WIDTH`-bit operand pair. It processes one 4-bit nibble per clock through a single 4-bit carry-lookahead slice, with the borrow held in a register between nibbles. It sits in the arithmetic library beside the combinational 4-bit CLA adder. It is the area-lean sequential counterpart for datapaths that need subtraction behind a valid/ready handshake.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be a multiple of 4 and at least 4; any other value is an elaboration error.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept operands.
- `a` in WIDTH: minuend.
- `b` in WIDTH: subtrahend.
- `bin` in 1: borrow in.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `diff` out WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout` out 1: borrow out. It is 1 iff unsigned `a < b + bin`.
- `overflow` out 1: signed overflow of the subtraction.

## Operation
- Arithmetic is `a + ~b + ~bin`.
  - Carry register is initialised to `~bin` at accept.
  - Each slice gets `a` nibble, `~b` nibble and carry.
  - `bout = ~carry_out` of the top nibble.
  - `overflow = c3 ^ c4` of the top nibble, where `c3` is the carry into the MSB and `c4` the carry out.
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid & in_ready`, latch `a`, `~b` and carry `~bin`, clear the nibble counter, then go to CALC.
  - CALC: each cycle processes nibble `cnt` (LSB first), writes `diff[4*cnt+3:4*cnt]`, updates the carry and increments `cnt`. On the cycle with `cnt == WIDTH/4-1`, also capture `bout` and `overflow`, then go to DONE.
  - DONE: `out_valid=1`. On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 0 in CALC and DONE. `in_valid`, `a`, `b` and `bin` are ignored outside IDLE.
- There is no overlap of operations; one operation is in flight at a time.
- `diff`, `bout` and `overflow` are held stable throughout DONE, however long `out_ready` stays low. After handoff they keep their last values until overwritten by the next operation; they are don't-care while `out_valid=0`.
- Reset priority: `rst` overrides every transition in any state. A reset mid-CALC or mid-DONE aborts the operation and no result is ever presented.

## Timing
- Reset values, effective after the first rising edge with `rst=1`:
  - state IDLE, `cnt=0`
  - `in_ready=1`, `out_valid=0`
  - `diff=0`, `bout=0`, `overflow=0`
- Let N = WIDTH/4 and E0 = the accepting edge.
  - Edges E1..EN process nibbles 0..N-1.
  - `out_valid` is 1 after edge EN, a latency of N cycles from accept.
- Handoff at edge EH, where `out_valid & out_ready`:
  - `out_valid=0` and `in_ready=1` after EH.
  - A new accept is possible at edge EH+1.
- Maximum throughput: one result per N+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sub_nibble_serial_pkg`:
  - constant `SLICE_W = 4`
  - state enum `{IDLE, CALC, DONE}`
  - function `nibbles(width)` returning `width/4`
- Sub-module `cla_slice_4`: combinational 4-bit carry-lookahead slice.
  - Generate `g = a & b`, propagate `p = a | b`, fully expanded carries `c1..c4`.
  - Sum is `a ^ b ^ c`.
  - Ports: `a[3:0]`, `b[3:0]`, `cin`, `sum[3:0]`, `c3`, `c4`.
- Top level: FSM, counter, operand/result registers and a nibble mux. Counter width is `$clog2(N)`, minimum 1 bit.

## Test plan
All cases use WIDTH=16.
- Basic: `a=0x1234`, `b=0x0034`, `bin=0` -> `diff=0x1200`, `bout=0`, `overflow=0`; `out_valid` rises exactly 4 cycles after accept.
- Unsigned underflow: `a=0x0000`, `b=0x0001`, `bin=0` -> `diff=0xFFFF`, `bout=1`, `overflow=0`.
- Signed overflow: `a=0x8000`, `b=0x0001` -> `diff=0x7FFF`, `bout=0`, `overflow=1`. Also `a=0x7FFF`, `b=0xFFFF` -> `diff=0x8000`, `bout=1`, `overflow=1`.
- Borrow-in ripple across nibbles: `a=0x0010`, `b=0x000F`, `bin=1` -> `diff=0x0000`, `bout=0`. Also `a=0`, `b=0`, `bin=1` -> `diff=0xFFFF`, `bout=1`.
- Backpressure and back-to-back:
  - Hold `out_ready=0` for 5 cycles in DONE: outputs stay stable and `in_ready=0`.
  - A new `in_valid` offered during that time is not accepted.
  - After the handoff, the held operation is accepted at EH+1.
- Reset mid-operation: assert `rst` on the 2nd CALC cycle -> next cycle `in_ready=1`, `out_valid=0`, `diff=0`. Issue `0x0005 - 0x0003` afterwards -> `diff=0x0002`.
